ysyx_22050612_exu_mc: RTL
=========================

# ysyx_22050612_exu_mc

Parametrised multi-cycle execute unit for the ysyx_22050612 RV64 core, replacing the single-cycle addi-only execute path. Takes decoded operands over a valid/ready handshake, computes the full RV64I integer ALU set plus word (*W) variants and an iterative low-half multiply, and presents a registered result, writeback enable and next PC downstream. The block sits between decode/register-read and writeback. The register file remains outside the block.

## Interface
- XLEN, 64: datapath width, 32 or 64; shift amount width is log2(XLEN)
- RST_PC_INC, 4: PC increment used for the link value and the default dnpc
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous kill of any in-flight or held operation
- in_valid  in  1  operand bundle valid
- in_ready  out  1  unit can accept a bundle this cycle
- in_op  in  4  operation code (see Operation)
- in_word  in  1  RV64 word mode (ignored when XLEN=32)
- in_src1, in_src2  in  XLEN  operands (src2 already holds imm when applicable)
- in_pc  in  XLEN  PC of the instruction
- in_rd  in  5  destination register
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_result  out  XLEN  writeback data
- out_rd  out  5  destination register
- out_wen  out  1  writeback enable
- out_dnpc  out  XLEN  next PC

## Operation
- Op codes:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND
  - 10 MUL: low XLEN bits of the product
  - 11 PASS: result = src2 (LUI)
  - 12 LINK: result = pc+RST_PC_INC, dnpc = (src1+src2) & ~1
  - 13–15 reserved: result 0, wen 0
- dnpc = pc+RST_PC_INC for every op except LINK.
- Word mode applies only to ops 0, 1, 2, 6, 7 and 10.
  - The op computes on src1[31:0]/src2[31:0]; shift amount is src2[4:0]; the 32-bit result is sign-extended to XLEN.
  - All other ops ignore in_word.
- Full-width shift amount is src2[log2(XLEN)-1:0]. SLT is signed, SLTU unsigned; result is 0 or 1.
- out_wen = 1 iff op is not reserved and in_rd != 0.
- FSM states:
  - IDLE: nothing held.
  - BUSY: multiply iterating.
  - HOLD: result registered, out_valid=1.
- FSM transitions:
  - IDLE/HOLD-being-drained + accept of a non-MUL op → HOLD.
  - Accept of MUL → BUSY, counter = N, where N = 32 in word mode, XLEN otherwise.
  - BUSY: one shift-add step per cycle (multiplicand <<1, multiplier >>1, accumulate when multiplier LSB is 1). Counter decrements; at 0 → HOLD.
  - HOLD & out_ready & no new accept → IDLE.
- in_ready = (state==IDLE) | (state==HOLD & out_ready). in_ready is 0 in BUSY.
- Accept = in_valid & in_ready & ~flush. The bundle is latched on accept.
- flush takes priority over everything: next state IDLE, out_valid cleared, multiply aborted, no accept that cycle.
- The accumulator is XLEN wide; overflow bits are discarded.

## Timing
- Reset (async, rst_n=0): state IDLE; out_valid, out_wen, out_result, out_rd and out_dnpc all 0; in_ready=1 once rst_n deasserts.
- Non-MUL latency: accepted at edge t → out_valid=1 after edge t. Back-to-back throughput is one per cycle when out_ready stays high.
- MUL latency: accepted at edge t → out_valid=1 after edge t+N, where N = 64 full or 32 word for XLEN=64.
- Outputs are stable while out_valid=1 and out_ready=0 (no change until consumed or flushed).
- A drain and an accept in the same cycle produce the new result after that edge with no bubble.
- Reset mid-MUL returns to IDLE immediately; partial results are lost.

## Test plan
- Reset then ADD with src1=5, src2=-3, rd=1, pc=0x80000000 → next cycle out_valid=1, result=2, wen=1, dnpc=0x80000004.
- Word ops:
  - ADDW with src1=0x7FFFFFFF, src2=1 → result 0xFFFFFFFF80000000.
  - SRAW with src1=0x80000000, src2=4 → result 0xFFFFFFFFF8000000.
- MUL with src1=0xFFFFFFFFFFFFFFFF, src2=3 → in_ready=0 for 64 cycles, then result 0xFFFFFFFFFFFFFFFD. The same operands as MULW → 32 busy cycles, result 0xFFFFFFFFFFFFFFFD.
- Backpressure: out_ready=0 for 5 cycles after a SUB of 10-20 → outputs held at 0xFFFFFFFFFFFFFFF6 and in_ready=0. On release, the queued ADD is accepted in the same cycle.
- LINK with src1=0x80001001, src2=4, rd=0 → dnpc=0x80001004, result=pc+4, wen=0. Reserved op 14 → wen=0, result=0.
- flush asserted on cycle 10 of a MUL → out_valid stays 0, in_ready=1 next cycle. rst_n pulsed mid-HOLD → out_valid drops asynchronously.

Source files
------------

// File: rtl/ysyx_22050612_exu_mc.sv
// Multi-cycle execute unit: RV64I integer ALU with word variants, an iterative
// shift-add low-half multiplier, and a registered result/wen/dnpc stage behind
// valid/ready handshakes on both sides.
module ysyx_22050612_exu_mc #(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned RST_PC_INC = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_op,
  input  logic            in_word,
  input  logic [XLEN-1:0] in_src1,
  input  logic [XLEN-1:0] in_src2,
  input  logic [XLEN-1:0] in_pc,
  input  logic [4:0]      in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            out_wen,
  output logic [XLEN-1:0] out_dnpc
);

  localparam int unsigned ShW  = $clog2(XLEN);
  localparam int unsigned CntW = $clog2(XLEN) + 1;
  // Word variants only exist on a 64-bit datapath.
  localparam bit WordEn = (XLEN == 64);
  localparam logic [XLEN-1:0] PcInc = XLEN'(RST_PC_INC);

  localparam logic [3:0] OpAdd  = 4'd0;
  localparam logic [3:0] OpSub  = 4'd1;
  localparam logic [3:0] OpSll  = 4'd2;
  localparam logic [3:0] OpSlt  = 4'd3;
  localparam logic [3:0] OpSltu = 4'd4;
  localparam logic [3:0] OpXor  = 4'd5;
  localparam logic [3:0] OpSrl  = 4'd6;
  localparam logic [3:0] OpSra  = 4'd7;
  localparam logic [3:0] OpOr   = 4'd8;
  localparam logic [3:0] OpAnd  = 4'd9;
  localparam logic [3:0] OpMul  = 4'd10;
  localparam logic [3:0] OpPass = 4'd11;
  localparam logic [3:0] OpLink = 4'd12;

  typedef enum logic [1:0] {StIdle, StBusy, StHold} state_e;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    sext32 = XLEN'($signed(v));
  endfunction

  state_e            state_q, state_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic [4:0]        rd_q, rd_d;
  logic              wen_q, wen_d;
  logic [XLEN-1:0]   dnpc_q, dnpc_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic [XLEN-1:0]   acc_q, acc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              mword_q, mword_d;

  logic              accept;
  logic              word_op;
  logic [31:0]       a32, b32, w_res;
  logic [XLEN-1:0]   f_res, alu_res, link_tgt, dnpc_c;
  logic              wen_c;
  logic [XLEN-1:0]   acc_nxt, mul_res;

  // Handshake decode; flush suppresses any accept in its cycle.
  always_comb begin
    in_ready  = (state_q == StIdle) | ((state_q == StHold) & out_ready);
    accept    = in_valid & in_ready & ~flush;
    out_valid = (state_q == StHold);
  end

  // Single-cycle ALU result, writeback enable and next PC for the incoming bundle.
  always_comb begin
    word_op  = WordEn && in_word &&
               (in_op inside {OpAdd, OpSub, OpSll, OpSrl, OpSra, OpMul});
    a32      = in_src1[31:0];
    b32      = in_src2[31:0];
    w_res    = '0;
    f_res    = '0;
    link_tgt = in_src1 + in_src2;
    link_tgt[0] = 1'b0;

    case (in_op)
      OpAdd:   w_res = a32 + b32;
      OpSub:   w_res = a32 - b32;
      OpSll:   w_res = a32 << b32[4:0];
      OpSrl:   w_res = a32 >> b32[4:0];
      OpSra:   w_res = $signed(a32) >>> b32[4:0];
      default: w_res = '0;
    endcase

    case (in_op)
      OpAdd:   f_res = in_src1 + in_src2;
      OpSub:   f_res = in_src1 - in_src2;
      OpSll:   f_res = in_src1 << in_src2[ShW-1:0];
      OpSlt:   f_res[0] = $signed(in_src1) < $signed(in_src2);
      OpSltu:  f_res[0] = in_src1 < in_src2;
      OpXor:   f_res = in_src1 ^ in_src2;
      OpSrl:   f_res = in_src1 >> in_src2[ShW-1:0];
      OpSra:   f_res = $signed(in_src1) >>> in_src2[ShW-1:0];
      OpOr:    f_res = in_src1 | in_src2;
      OpAnd:   f_res = in_src1 & in_src2;
      OpPass:  f_res = in_src2;
      OpLink:  f_res = in_pc + PcInc;
      default: f_res = '0;
    endcase

    alu_res = word_op ? sext32(w_res) : f_res;
    // Ops 13..15 are reserved and never write back.
    wen_c   = (in_op <= OpLink) && (in_rd != 5'd0);
    dnpc_c  = (in_op == OpLink) ? link_tgt : (in_pc + PcInc);
  end

  // One shift-add multiply step on the held operands.
  always_comb begin
    acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);
    mul_res = mword_q ? sext32(acc_nxt[31:0]) : acc_nxt;
  end

  // Next-state: flush first, then accept/drain in IDLE/HOLD, iterate in BUSY.
  always_comb begin
    state_d  = state_q;
    res_d    = res_q;
    rd_d     = rd_q;
    wen_d    = wen_q;
    dnpc_d   = dnpc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    mword_d  = mword_q;

    if (flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle, StHold: begin
          if (accept) begin
            rd_d   = in_rd;
            wen_d  = wen_c;
            dnpc_d = dnpc_c;
            if (in_op == OpMul) begin
              state_d  = StBusy;
              // Low half of the product only depends on the low operand bits.
              mcand_d  = word_op ? XLEN'(in_src1[31:0]) : in_src1;
              mplier_d = word_op ? XLEN'(in_src2[31:0]) : in_src2;
              acc_d    = '0;
              cnt_d    = word_op ? CntW'(32) : CntW'(XLEN);
              mword_d  = word_op;
            end else begin
              state_d = StHold;
              res_d   = alu_res;
            end
          end else if ((state_q == StHold) && out_ready) begin
            state_d = StIdle;
          end
        end
        StBusy: begin
          acc_d    = acc_nxt;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            state_d = StHold;
            res_d   = mul_res;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and registered outputs; async reset clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      res_q    <= '0;
      rd_q     <= '0;
      wen_q    <= 1'b0;
      dnpc_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      mword_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      res_q    <= res_d;
      rd_q     <= rd_d;
      wen_q    <= wen_d;
      dnpc_q   <= dnpc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      mword_q  <= mword_d;
    end
  end

  assign out_result = res_q;
  assign out_rd     = rd_q;
  assign out_wen    = wen_q;
  assign out_dnpc   = dnpc_q;

endmodule
